// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (Booth radix-2) / restoring divide unit writing HI/LO.
// Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned input for multu/divu.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divby0flag
`ifdef MULT_DIV_UNSIGNED_EN
  ,
  input  logic             is_unsigned
`endif
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WB} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               isdiv_q, isdiv_d;
  logic               uns_q, uns_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               uns_in;
  logic [WIDTH-1:0]   upper, lower, mag_a, mag_b;
  logic [WIDTH:0]     up_ext, m_ext, sum, shifted, diff;

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // acc layout: {upper, lower, booth_q-1}; divide keeps {remainder, quotient, unused}
  assign upper = acc_q[2*WIDTH:WIDTH+1];
  assign lower = acc_q[WIDTH:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isdiv_d = isdiv_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    mag_a   = (!uns_in && a[WIDTH-1]) ? -a : a;
    mag_b   = (!uns_in && b[WIDTH-1]) ? -b : b;

    // One guard bit keeps the add/subtract exact before the arithmetic shift
    up_ext  = uns_q ? {1'b0, upper} : {upper[WIDTH-1], upper};
    m_ext   = uns_q ? {1'b0, mcand_q} : {mcand_q[WIDTH-1], mcand_q};
    if (uns_q) begin
      sum = acc_q[1] ? up_ext + m_ext : up_ext;
    end else begin
      case (acc_q[1:0])
        2'b01:   sum = up_ext + m_ext;
        2'b10:   sum = up_ext - m_ext;
        default: sum = up_ext;
      endcase
    end

    shifted = {upper, lower[WIDTH-1]};
    diff    = shifted - {1'b0, mcand_q};

    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MUL;
          acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
          mcand_d = a;
          isdiv_d = 1'b0;
          uns_d   = uns_in;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (start_div) begin
          if (b == '0) begin
            dz_d = 1'b1;
          end else begin
            state_d = DIV;
            acc_d   = {{WIDTH{1'b0}}, mag_a, 1'b0};
            mcand_d = mag_b;
            isdiv_d = 1'b1;
            uns_d   = uns_in;
            negq_d  = !uns_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = !uns_in && a[WIDTH-1];
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (state_q == MUL) begin
          acc_d = {sum, acc_q[WIDTH:1]};
        end else if (!diff[WIDTH]) begin
          acc_d = {diff[WIDTH-1:0], lower[WIDTH-2:0], 1'b1, 1'b0};
        end else begin
          acc_d = {shifted[WIDTH-1:0], lower[WIDTH-2:0], 1'b0, 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        if (isdiv_q) begin
          acc_d = {negr_q ? -upper : upper, negq_q ? -lower : lower, 1'b0};
        end
        state_d = WB;
      end
      WB: begin
        hi_d    = upper;
        lo_d    = lower;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isdiv_q <= 1'b0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isdiv_q <= isdiv_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign divby0flag = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a 64-bit arithmetic reference model.
// Unsigned cases run only when MULT_DIV_UNSIGNED_EN is defined.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divby0flag;
  logic        is_unsigned;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .divby0flag (divby0flag)
`ifdef MULT_DIV_UNSIGNED_EN
    ,
    .is_unsigned(is_unsigned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic void ref_model(input bit is_div, input bit uns,
                                    input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    if (!is_div && !uns) begin
      sp = sa * sb;
      eh = sp[63:32];
      el = sp[31:0];
    end else if (!is_div) begin
      up = ua * ub;
      eh = up[63:32];
      el = up[31:0];
    end else if (!uns) begin
      sq = sa / sb;
      sr = sa % sb;
      eh = sr[31:0];
      el = sq[31:0];
    end else begin
      up = ua / ub;
      eh = 32'(ua % ub);
      el = up[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation and observes 50 cycles after the accepting edge.
  task automatic run_op(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                        input bit uns, output int done_at, output int busy_cycles,
                        output int done_cnt, output logic [31:0] rhi, output logic [31:0] rlo);
    @(negedge clk);
    a = av; b = bv; is_unsigned = uns;
    start_mult = !is_div; start_div = is_div;
    @(posedge clk);
    #1;
    start_mult = 1'b0; start_div = 1'b0;
    a = $urandom; b = $urandom; is_unsigned = $urandom_range(0, 1);
    done_at = -1; busy_cycles = 0; done_cnt = 0; rhi = 'x; rlo = 'x;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k; rhi = hi; rlo = lo;
        end
      end
    end
  endtask

  task automatic check_op(input string name, input bit is_div, input logic [31:0] av,
                          input logic [31:0] bv, input bit uns);
    int          dat, bcy, dcn;
    logic [31:0] rh, rl, eh, el;
    ref_model(is_div, uns, av, bv, eh, el);
    run_op(is_div, av, bv, uns, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl} !== {eh, el}) begin
      errors++;
      $display("FAIL %s result a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
               name, av, bv, rh, rl, eh, el);
    end
    checks++;
    if (dat !== 35 || bcy !== 34 || dcn !== 1) begin
      errors++;
      $display("FAIL %s timing: got done_at=%0d busy_cycles=%0d done_pulses=%0d expected 35/34/1",
               name, dat, bcy, dcn);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0; is_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, divby0flag} !== 67'd0) begin
      errors++;
      $display("FAIL reset_held: got hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
               hi, lo, busy, done, divby0flag);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, divby0flag} !== 67'd0) begin
      errors++;
      $display("FAIL reset_release: got hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
               hi, lo, busy, done, divby0flag);
    end
  endtask

  task automatic test_directed();
    int          dat, bcy, dcn;
    logic [31:0] rh, rl;
    run_op(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      errors++;
      $display("FAIL mul_m3x7: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", rh, rl);
    end
    checks++;
    if (dat !== 35 || bcy !== 34 || dcn !== 1) begin
      errors++;
      $display("FAIL mul_m3x7_timing: got done_at=%0d busy=%0d pulses=%0d expected 35/34/1",
               dat, bcy, dcn);
    end
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_m7d2: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", rh, rl);
    end
    run_op(1'b1, 32'd100, 32'd7, 1'b0, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl} !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL div_100d7: got hi=%h lo=%h expected hi=2 lo=14", rh, rl);
    end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl, divby0flag} !== {32'd0, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL div_min_m1: got hi=%h lo=%h expected hi=0 lo=80000000", rh, rl);
    end
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, dat, bcy, dcn, rh, rl);
    checks++;
    if ({rh, rl} !== {32'h4000_0000, 32'd0}) begin
      errors++;
      $display("FAIL mul_min_min: got hi=%h lo=%h expected hi=40000000 lo=0", rh, rl);
    end
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      av = pick_operand();
      bv = pick_operand();
      if (i % 2 == 1 && bv == 32'd0) bv = 32'd3;
      check_op((i % 2 == 1) ? "rand_div" : "rand_mul", i % 2 == 1, av, bv, 1'b0);
    end
  endtask

  task automatic test_divby0();
    int busy_seen, done_seen;
    logic fl1, fl2;
    check_op("preload", 1'b1, 32'h0000_3412, 32'h0000_0100, 1'b0);
    @(negedge clk);
    a = $urandom; b = 32'd0; start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0; b = $urandom;
    busy_seen = 0; done_seen = 0; fl1 = 1'b0; fl2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) fl1 = divby0flag;
      if (k == 2) fl2 = divby0flag;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    checks++;
    if (fl1 !== 1'b1 || fl2 !== 1'b0) begin
      errors++;
      $display("FAIL div0_flag: got pulse=%b after=%b expected 1 then 0", fl1, fl2);
    end
    checks++;
    if (busy_seen !== 0 || done_seen !== 0) begin
      errors++;
      $display("FAIL div0_busy_done: got busy_cycles=%0d done_cycles=%0d expected 0/0",
               busy_seen, done_seen);
    end
    checks++;
    if ({hi, lo} !== {32'h12, 32'h34}) begin
      errors++;
      $display("FAIL div0_hold: got hi=%h lo=%h expected hi=12 lo=34", hi, lo);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] av, bv, eh, el, rh, rl;
    int          dat;
    av = $urandom; bv = $urandom;
    ref_model(1'b0, 1'b0, av, bv, eh, el);
    @(negedge clk);
    a = av; b = bv; start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0; a = $urandom; b = $urandom;
    dat = -1; rh = 'x; rl = 'x;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done && dat < 0) begin
        dat = k; rh = hi; rl = lo;
      end
      if (k == 10) begin
        a = 32'd1; b = 32'd1; start_div = 1'b1;
      end
      if (k == 11) start_div = 1'b0;
    end
    checks++;
    if ({rh, rl} !== {eh, el} || dat !== 35) begin
      errors++;
      $display("FAIL busy_ignore: got hi=%h lo=%h done_at=%0d expected hi=%h lo=%h done_at=35",
               rh, rl, dat, eh, el);
    end
    av = pick_operand(); bv = 32'd5;
    ref_model(1'b0, 1'b0, av, bv, eh, el);
    @(negedge clk);
    a = av; b = bv; start_mult = 1'b1; start_div = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0; start_div = 1'b0;
    dat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done && dat < 0) begin
        dat = k; rh = hi; rl = lo;
      end
    end
    checks++;
    if ({rh, rl} !== {eh, el} || dat !== 35) begin
      errors++;
      $display("FAIL both_starts: got hi=%h lo=%h done_at=%0d expected hi=%h lo=%h done_at=35",
               rh, rl, dat, eh, el);
    end
  endtask

  task automatic test_reset_midop();
    int done_seen, busy_seen;
    @(negedge clk);
    a = 32'h0001_2345; b = 32'd17; start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo, busy} !== 65'd0) begin
      errors++;
      $display("FAIL reset_midop: got hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0; busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL reset_abort: got done_cycles=%0d busy_cycles=%0d expected 0/0",
               done_seen, busy_seen);
    end
    check_op("after_reset", 1'b1, 32'hFFFF_FF00, 32'd9, 1'b0);
  endtask

`ifdef MULT_DIV_UNSIGNED_EN
  task automatic test_unsigned();
    check_op("multu_max2", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_op("rand_multu", 1'b0, pick_operand(), pick_operand(), 1'b1);
      check_op("rand_divu", 1'b1, pick_operand(), pick_operand() | 32'h1, 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_divby0();
    test_start_while_busy();
    test_reset_midop();
`ifdef MULT_DIV_UNSIGNED_EN
    test_unsigned();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
